// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Single-issue RV64I integer execution slice. The instruction word is decoded
// combinationally in the issue cycle while the register file is read through
// rs1_idx/rs2_idx. One pipeline register captures the decoded fields and the
// operands, and a combinational ALU produces the write-back in the next cycle.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high; clears the pipeline register
//   inst      in  32   instruction word presented this cycle
//   pc        in  64   PC of inst
//   i_valid   in   1   inst is valid and its operands are ready
//   rs1_idx   out  5   inst[19:15], combinational, to the register file
//   rs2_idx   out  5   inst[24:20], combinational, to the register file
//   rs1_data  in  64   register-file read data for rs1_idx (same cycle)
//   rs2_data  in  64   register-file read data for rs2_idx (same cycle)
//   result    out 64   ALU result of the registered instruction (0 if unsupported)
//   o_rd_idx  out  5   destination index of the registered instruction
//   o_valid   out  1   result is a valid write-back (register-file write enable)
//
// Handshake: there is no backpressure. An instruction with i_valid=1 in cycle N
// is written back with o_valid=1 in cycle N+1 if it is a supported encoding;
// the instruction is never held, and a new one may be presented every cycle.
// -----------------------------------------------------------------------------
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [63:0] pc,
    input  logic        i_valid,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    output logic [63:0] result,
    output logic [4:0]  o_rd_idx,
    output logic        o_valid
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // ------------------------------------------------------------------
    // Decode (issue cycle)
    // ------------------------------------------------------------------
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_func3;
    logic [6:0]  dec_func7;
    logic [4:0]  dec_rd;
    logic [19:0] dec_imm;

    assign dec_opcode = inst[6:0];
    assign dec_func3  = inst[14:12];
    assign dec_func7  = inst[31:25];
    assign dec_rd     = inst[11:7];
    assign rs1_idx    = inst[19:15];
    assign rs2_idx    = inst[24:20];

    // A single 20-bit immediate field serves both formats: U-type keeps the
    // upper 20 bits, every other format keeps the I-type 12 bits sign-extended.
    always_comb begin
        dec_imm = {{8{inst[31]}}, inst[31:20]};
        if (dec_opcode == OPC_LUI || dec_opcode == OPC_AUIPC) begin
            dec_imm = inst[31:12];
        end
    end

    // ------------------------------------------------------------------
    // Pipeline register (no enable; captures every edge)
    // ------------------------------------------------------------------
    logic [6:0]  r_opcode;
    logic [2:0]  r_func3;
    logic [6:0]  r_func7;
    logic [19:0] r_imm;
    logic [63:0] r_rs1;
    logic [63:0] r_rs2;
    logic [63:0] r_pc;
    logic        r_valid;
    logic [4:0]  r_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= '0;
            r_func3  <= '0;
            r_func7  <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_rd     <= '0;
        end else begin
            r_opcode <= dec_opcode;
            r_func3  <= dec_func3;
            r_func7  <= dec_func7;
            r_imm    <= dec_imm;
            r_rs1    <= rs1_data;
            r_rs2    <= rs2_data;
            r_pc     <= pc;
            r_valid  <= i_valid;
            r_rd     <= dec_rd;
        end
    end

    // ------------------------------------------------------------------
    // Execute (write-back cycle)
    // ------------------------------------------------------------------
    logic [63:0] u_imm;
    logic [63:0] i_imm;
    logic        func7_ok;

    assign u_imm    = {{32{r_imm[19]}}, r_imm, 12'b0};
    assign i_imm    = {{52{r_imm[11]}}, r_imm[11:0]};
    // Register-register forms only accept the base and the alternate (SUB/SRA)
    // func7; anything else (e.g. the M extension) is reported unsupported.
    assign func7_ok = (r_func7 == 7'b0000000) || (r_func7 == 7'b0100000);

    logic [63:0] alu_res;
    logic        alu_ok;
    logic [31:0] w_res;

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b0;
        w_res   = '0;
        case (r_opcode)
            OPC_LUI: begin
                alu_ok  = 1'b1;
                alu_res = u_imm;
            end
            OPC_AUIPC: begin
                alu_ok  = 1'b1;
                alu_res = r_pc + u_imm;
            end
            OPC_OP_IMM: begin
                alu_ok = 1'b1;
                case (r_func3)
                    3'b000: alu_res = r_rs1 + i_imm;
                    3'b010: alu_res = {63'b0, $signed(r_rs1) < $signed(i_imm)};
                    3'b011: alu_res = {63'b0, r_rs1 < i_imm};
                    3'b100: alu_res = r_rs1 ^ i_imm;
                    3'b110: alu_res = r_rs1 | i_imm;
                    3'b111: alu_res = r_rs1 & i_imm;
                    3'b001: alu_res = r_rs1 << r_imm[5:0];
                    3'b101: begin
                        // Kept as separate statements so the arithmetic shift
                        // is not turned unsigned by a mixed-sign ternary.
                        if (r_func7[5]) begin
                            alu_res = $signed(r_rs1) >>> r_imm[5:0];
                        end else begin
                            alu_res = r_rs1 >> r_imm[5:0];
                        end
                    end
                    default: alu_res = '0;
                endcase
            end
            OPC_OP: begin
                if (func7_ok) begin
                    alu_ok = 1'b1;
                    case (r_func3)
                        3'b000: begin
                            if (r_func7[5]) begin
                                alu_res = r_rs1 - r_rs2;
                            end else begin
                                alu_res = r_rs1 + r_rs2;
                            end
                        end
                        3'b001: alu_res = r_rs1 << r_rs2[5:0];
                        3'b010: alu_res = {63'b0, $signed(r_rs1) < $signed(r_rs2)};
                        3'b011: alu_res = {63'b0, r_rs1 < r_rs2};
                        3'b100: alu_res = r_rs1 ^ r_rs2;
                        3'b101: begin
                            if (r_func7[5]) begin
                                alu_res = $signed(r_rs1) >>> r_rs2[5:0];
                            end else begin
                                alu_res = r_rs1 >> r_rs2[5:0];
                            end
                        end
                        3'b110: alu_res = r_rs1 | r_rs2;
                        3'b111: alu_res = r_rs1 & r_rs2;
                        default: alu_res = '0;
                    endcase
                end
            end
            OPC_OP_IMM_32: begin
                case (r_func3)
                    3'b000: begin
                        alu_ok = 1'b1;
                        w_res  = r_rs1[31:0] + i_imm[31:0];
                    end
                    3'b001: begin
                        alu_ok = 1'b1;
                        w_res  = r_rs1[31:0] << r_imm[4:0];
                    end
                    3'b101: begin
                        alu_ok = 1'b1;
                        if (r_func7[5]) begin
                            w_res = $signed(r_rs1[31:0]) >>> r_imm[4:0];
                        end else begin
                            w_res = r_rs1[31:0] >> r_imm[4:0];
                        end
                    end
                    default: alu_ok = 1'b0;
                endcase
                alu_res = {{32{w_res[31]}}, w_res};
            end
            OPC_OP_32: begin
                if (func7_ok) begin
                    case (r_func3)
                        3'b000: begin
                            alu_ok = 1'b1;
                            if (r_func7[5]) begin
                                w_res = r_rs1[31:0] - r_rs2[31:0];
                            end else begin
                                w_res = r_rs1[31:0] + r_rs2[31:0];
                            end
                        end
                        3'b001: begin
                            alu_ok = 1'b1;
                            w_res  = r_rs1[31:0] << r_rs2[4:0];
                        end
                        3'b101: begin
                            alu_ok = 1'b1;
                            if (r_func7[5]) begin
                                w_res = $signed(r_rs1[31:0]) >>> r_rs2[4:0];
                            end else begin
                                w_res = r_rs1[31:0] >> r_rs2[4:0];
                            end
                        end
                        default: alu_ok = 1'b0;
                    endcase
                end
                alu_res = {{32{w_res[31]}}, w_res};
            end
            default: begin
                alu_ok  = 1'b0;
                alu_res = '0;
            end
        endcase
    end

    // Unsupported encodings force a zero result; the result is otherwise
    // produced even when the registered instruction was not valid.
    assign result   = alu_ok ? alu_res : 64'd0;
    assign o_valid  = r_valid & alu_ok;
    assign o_rd_idx = r_rd;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed steps for reset, the worked examples and unsupported encodings,
// followed by a stream of randomized RV64I instructions (one per cycle) checked
// against an arithmetic reference model of the instruction set.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  // clock / reset block
  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        i_valid;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] result;
  logic [4:0]  o_rd_idx;
  logic        o_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  alu_exec_unit dut (
    .clk      (clk),
    .reset    (reset),
    .inst     (inst),
    .pc       (pc),
    .i_valid  (i_valid),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .result   (result),
    .o_rd_idx (o_rd_idx),
    .o_valid  (o_valid)
  );

  // scoreboard: {o_valid, o_rd_idx, result}
  logic [69:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference model: architectural meaning of one instruction
  function automatic logic [69:0] model(input logic [31:0] ins, input logic [63:0] p,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic v);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] immi;
    logic [63:0] immu;
    logic [63:0] r;
    logic [31:0] ua;
    longint      sa;
    longint      sb;
    longint      si;
    int          wa;
    int          wb;
    int          wr;
    bit          ok;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    immi = {{52{ins[31]}}, ins[31:20]};
    immu = {{32{ins[31]}}, ins[31:12], 12'h000};
    sa   = a;
    sb   = b;
    si   = immi;
    ua   = a[31:0];
    wa   = a[31:0];
    wb   = b[31:0];
    wr   = 0;
    r    = 64'd0;
    ok   = 1'b1;
    case (opc)
      7'h37: r = immu;
      7'h17: r = p + immu;
      7'h13: begin
        case (f3)
          3'd0: r = a + immi;
          3'd2: r = (sa < si) ? 64'd1 : 64'd0;
          3'd3: r = (a < immi) ? 64'd1 : 64'd0;
          3'd4: r = a ^ immi;
          3'd6: r = a | immi;
          3'd7: r = a & immi;
          3'd1: r = a << ins[25:20];
          default: r = ins[30] ? 64'(sa >>> ins[25:20]) : (a >> ins[25:20]);
        endcase
      end
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20);
        case (f3)
          3'd0: r = ins[30] ? a - b : a + b;
          3'd1: r = a << b[5:0];
          3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
          3'd3: r = (a < b) ? 64'd1 : 64'd0;
          3'd4: r = a ^ b;
          3'd5: r = ins[30] ? 64'(sa >>> b[5:0]) : (a >> b[5:0]);
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
      7'h1b: begin
        case (f3)
          3'd0: wr = wa + int'(si);
          3'd1: wr = int'(ua << ins[24:20]);
          3'd5: wr = ins[30] ? (wa >>> ins[24:20]) : int'(ua >> ins[24:20]);
          default: ok = 1'b0;
        endcase
        r = 64'(longint'(wr));
      end
      7'h3b: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20);
        case (f3)
          3'd0: wr = ins[30] ? wa - wb : wa + wb;
          3'd1: wr = int'(ua << b[4:0]);
          3'd5: wr = ins[30] ? (wa >>> b[4:0]) : int'(ua >> b[4:0]);
          default: ok = 1'b0;
        endcase
        r = 64'(longint'(wr));
      end
      default: ok = 1'b0;
    endcase
    if (!ok) r = 64'd0;
    return {v & ok, ins[11:7], r};
  endfunction

  // stimulus generators
  function automatic logic [63:0] pick_data();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [11:0] i12;
    logic [19:0] i20;
    logic [5:0]  sh6;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alt;
    logic [31:0] rnd;
    rd  = 5'($urandom_range(0, 31));
    r1  = 5'($urandom_range(0, 31));
    r2  = 5'($urandom_range(0, 31));
    i12 = 12'($urandom);
    i20 = 20'($urandom);
    sh6 = 6'($urandom_range(0, 63));
    alt = 1'($urandom_range(0, 1));
    rnd = $urandom;
    case ($urandom_range(0, 13))
      0: return {i20, rd, 7'h37};
      1: return {i20, rd, 7'h17};
      2: begin
        do f3 = 3'($urandom_range(0, 7)); while (f3 == 3'd1 || f3 == 3'd5);
        return {i12, r1, f3, rd, 7'h13};
      end
      3: return {6'b0, sh6, r1, 3'b001, rd, 7'h13};
      4: return {1'b0, alt, 4'b0, sh6, r1, 3'b101, rd, 7'h13};
      5, 6: begin
        f3 = 3'($urandom_range(0, 7));
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && alt) ? 7'h20 : 7'h00;
        return {f7, r2, r1, f3, rd, 7'h33};
      end
      7: return {i12, r1, 3'b000, rd, 7'h1b};
      8: return {7'b0, sh6[4:0], r1, 3'b001, rd, 7'h1b};
      9: return {1'b0, alt, 5'b0, sh6[4:0], r1, 3'b101, rd, 7'h1b};
      10: begin
        case ($urandom_range(0, 2))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          default: f3 = 3'd5;
        endcase
        f7 = (f3 != 3'd1 && alt) ? 7'h20 : 7'h00;
        return {f7, r2, r1, f3, rd, 7'h3b};
      end
      11: return {rnd[31:7], alt ? 7'h73 : 7'h03};
      12: return {7'h01, r2, r1, 3'($urandom_range(0, 7)), rd, 7'h33};
      default: begin
        do f3 = 3'($urandom_range(0, 7)); while (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
        return {7'h00, r2, r1, f3, rd, 7'h3b};
      end
    endcase
  endfunction

  // driver: present one instruction for one cycle and check its write-back
  task automatic step(input string tag, input logic [31:0] ins, input logic [63:0] p,
                      input logic [63:0] a, input logic [63:0] b, input logic v,
                      input logic rst, input logic [69:0] e);
    logic [69:0] x;
    inst     = ins;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
    i_valid  = v;
    reset    = rst;
    exp_q.push_back(e);
    #1;
    check({tag, ".rs1_idx"}, 64'(rs1_idx), 64'(ins[19:15]));
    check({tag, ".rs2_idx"}, 64'(rs2_idx), 64'(ins[24:20]));
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check({tag, ".o_valid"},  64'(o_valid),  64'(x[69]));
    check({tag, ".o_rd_idx"}, 64'(o_rd_idx), 64'(x[68:64]));
    check({tag, ".result"},   result,        x[63:0]);
  endtask

  localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;

  initial begin
    logic [31:0] ins;
    logic [63:0] p;
    logic [63:0] a;
    logic [63:0] b;
    logic        v;
    logic        rst;
    reset    = 1'b1;
    inst     = '0;
    pc       = '0;
    rs1_data = '0;
    rs2_data = '0;
    i_valid  = 1'b0;

    // reset held for two edges with a valid ADDI presented: dropped
    step("reset0", ADDI_X1_5, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 70'd0);
    step("reset1", ADDI_X1_5, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 70'd0);

    // worked examples
    step("addi",  ADDI_X1_5,    64'h0, 64'd0, 64'd0, 1'b1, 1'b0, {1'b1, 5'd1, 64'd5});
    step("sub",   32'h4020_81B3, 64'h4, 64'd3, 64'd5, 1'b1, 1'b0,
         {1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE});
    step("addw",  32'h0020_823B, 64'h8, 64'h7FFF_FFFF, 64'd1, 1'b1, 1'b0,
         {1'b1, 5'd4, 64'hFFFF_FFFF_8000_0000});
    step("srai",  32'h43F0_D293, 64'hC, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0,
         {1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF});
    step("srli",  32'h03F0_D293, 64'h10, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0,
         {1'b1, 5'd5, 64'd1});
    step("auipc", 32'h0000_1317, 64'hFFFF_0000_2432_2317, 64'd0, 64'd0, 1'b1, 1'b0,
         {1'b1, 5'd6, 64'hFFFF_0000_2432_3317});
    step("lui",   32'h8000_03B7, 64'h14, 64'd0, 64'd0, 1'b1, 1'b0,
         {1'b1, 5'd7, 64'hFFFF_FFFF_8000_0000});
    step("slt",   32'h0020_A433, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
         {1'b1, 5'd8, 64'd1});
    step("sltu",  32'h0020_B433, 64'h1C, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
         {1'b1, 5'd8, 64'd0});
    step("sltiu", 32'hFFF0_B493, 64'h20, 64'd5, 64'd0, 1'b1, 1'b0,
         {1'b1, 5'd9, 64'd1});

    // unsupported encodings and an invalid slot
    step("ecall", 32'h0000_0073, 64'h24, 64'd7, 64'd9, 1'b1, 1'b0, {1'b0, 5'd0, 64'd0});
    step("mul",   32'h0231_00B3, 64'h28, 64'd7, 64'd9, 1'b1, 1'b0, {1'b0, 5'd1, 64'd0});
    step("op32f3", 32'h0031_20BB, 64'h2C, 64'd7, 64'd9, 1'b1, 1'b0, {1'b0, 5'd1, 64'd0});
    step("novalid", ADDI_X1_5, 64'h30, 64'd0, 64'd0, 1'b0, 1'b0, {1'b0, 5'd1, 64'd5});

    // reset mid-stream discards the in-flight instruction
    step("pre_rst", 32'h0010_8113, 64'h34, 64'd10, 64'd0, 1'b1, 1'b0, {1'b1, 5'd2, 64'd11});
    step("mid_rst", 32'h0010_8113, 64'h38, 64'd10, 64'd0, 1'b1, 1'b1, 70'd0);

    // randomized back-to-back stream against the reference model
    for (int i = 0; i < 38; i++) begin
      ins = gen_inst();
      p   = {$urandom, $urandom};
      a   = pick_data();
      b   = pick_data();
      v   = ($urandom_range(0, 7) != 0);
      rst = (i == 25);
      step($sformatf("stream%0d", i), ins, p, a, b, v, rst,
           rst ? 70'd0 : model(ins, p, a, b, v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
